fp32_to_fixed: RTL

- Pipelined converter from IEEE-754 single precision to signed two's-complement fixed point.
- It is the decode direction of the SFU float adder: unpack, align and round, versus normalize, round and pack.
- It feeds SFU results into integer and fixed-point datapaths.
- Uses the same 3-stage, global-enable, valid-tagged pipeline style as the adder, so both units can share a stall signal.

---
 rtl/fp32_to_fixed_pkg.sv | 26 ++
 rtl/dff_en.sv | 23 ++
 rtl/fp32_to_fixed_align.sv | 51 +++++
 rtl/fp32_to_fixed.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fp32_to_fixed_pkg.sv
// Shared SFU definitions: FP32 field geometry, special-exponent encoding,
// the packed FP32 view used by both the float adder and this converter,
// and the rounding-mode enumeration (only round-to-nearest-even is built).
package fp32_to_fixed_pkg;

    localparam int FP32_W         = 32;
    localparam int FP32_EXPO_W    = 8;
    localparam int FP32_MANT_W    = 23;
    localparam int FP32_EXPO_BIAS = 127;

    localparam logic [FP32_EXPO_W-1:0] EXPO_ALL_ONES = {FP32_EXPO_W{1'b1}};

    typedef struct packed {
        logic                   sign;
        logic [FP32_EXPO_W-1:0] expo;
        logic [FP32_MANT_W-1:0] mant;
    } fp32_t;

    typedef enum logic [1:0] {
        RND_RNE = 2'd0,
        RND_RTZ = 2'd1,
        RND_RUP = 2'd2,
        RND_RDN = 2'd3
    } rnd_mode_e;

endpackage

// File: rtl/dff_en.sv
// Enable-gated register cell with asynchronous active-high reset.
// Every pipeline flop of the SFU units is built from this cell.
module dff_en #(
    parameter int         W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // Hold unless enabled; reset forces the reset value at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_o <= RST_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/fp32_to_fixed_align.sv
// fix_align_shifter: bidirectional barrel shifter for the align stage.
// A non-negative shift moves the 24-bit significand left into the output
// field; a negative shift moves it right and collects guard/sticky bits.
module fix_align_shifter #(
    parameter int MANT_WIDTH = 23,
    parameter int OUT_WIDTH  = 32,
    parameter int SH_W       = 10
) (
    input  logic                   [MANT_WIDTH:0] m24_i,
    input  logic signed            [SH_W-1:0]     sh_i,
    output logic                   [OUT_WIDTH-1:0] mag_o,
    output logic                                   guard_o,
    output logic                                   sticky_o,
    output logic                                   ovf_o
);

    localparam int MW = MANT_WIDTH + 1;
    localparam int RW = 2 * MW + 2;

    logic [SH_W-1:0]      amt;
    logic [OUT_WIDTH-1:0] lext;
    logic [RW-1:0]        rext;
    logic [RW-1:0]        rsh;

    // Select shift direction from the sign of sh and form magnitude/guard/sticky.
    always_comb begin
        amt      = sh_i[SH_W-1] ? SH_W'(-sh_i) : SH_W'(sh_i);
        lext     = {{(OUT_WIDTH-MW){1'b0}}, m24_i};
        rext     = {m24_i, {(MW+2){1'b0}}};
        rsh      = '0;
        mag_o    = '0;
        guard_o  = 1'b0;
        sticky_o = 1'b0;
        ovf_o    = 1'b0;
        if (!sh_i[SH_W-1]) begin
            mag_o = lext << amt;
            // Flag only shifts that push set bits past the MSB. A shift that
            // lands exactly on 2^(OUT_WIDTH-1) still fits and is resolved by
            // the saturation compare, so -2^(OUT_WIDTH-1) stays exact.
            ovf_o = (amt > SH_W'(OUT_WIDTH - MW));
        end else if (amt > SH_W'(MW + 1)) begin
            sticky_o = 1'b1;
        end else begin
            rsh      = rext >> amt;
            mag_o    = {{(OUT_WIDTH-MW){1'b0}}, rsh[RW-1:MW+2]};
            guard_o  = rsh[MW+1];
            sticky_o = |rsh[MW:0];
        end
    end

endmodule

// File: rtl/fp32_to_fixed.sv
// fp32_to_fixed: 3-stage IEEE-754 single -> signed fixed-point converter.
// Stage 0 unpacks, stage 1 aligns, stage 2 rounds (RNE), signs and
// saturates. en freezes all stages; valid is a tag riding with the data.
// Optional build macro FP2FIX_STATUS_EN adds status = {nan, sat, inexact}.
module fp32_to_fixed
    import fp32_to_fixed_pkg::*;
#(
    parameter int DATA_WIDTH = FP32_W,
    parameter int EXPO_WIDTH = FP32_EXPO_W,
    parameter int MANT_WIDTH = FP32_MANT_W,
    parameter int OUT_WIDTH  = 32,
    parameter int EXPO_BIAS  = FP32_EXPO_BIAS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         vld_in,
    input  logic [DATA_WIDTH-1:0]        Oprand,
    input  logic [$clog2(OUT_WIDTH)-1:0] frac_bits,
    output logic [OUT_WIDTH-1:0]         Result,
    output logic                         vld_out
`ifdef FP2FIX_STATUS_EN
    ,
    output logic [2:0]                   status
`endif
);

    localparam int SH_W = EXPO_WIDTH + 2;

    localparam logic [OUT_WIDTH:0]   LIM  = {2'b01, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] MAXP = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] MINN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic                   sign;
        logic                   zero_den;
        logic                   inf;
        logic                   nan;
        logic signed [SH_W-1:0] sh;
        logic [MANT_WIDTH:0]    m24;
    } s0_t;

    typedef struct packed {
        logic                 sign;
        logic                 zero_den;
        logic                 inf;
        logic                 nan;
        logic                 ovf;
        logic                 guard;
        logic                 sticky;
        logic [OUT_WIDTH-1:0] mag;
    } s1_t;

    function automatic logic rne_inc(input logic guard, input logic sticky,
                                     input logic lsb);
        return guard & (sticky | lsb);
    endfunction

    function automatic logic sat_check(input logic sign, input logic ovf,
                                       input logic [OUT_WIDTH:0] mag_r);
        if (ovf) return 1'b1;
        return sign ? (mag_r > LIM) : (mag_r >= LIM);
    endfunction

    logic [EXPO_WIDTH-1:0] expo;
    logic [MANT_WIDTH-1:0] mant;
    s0_t                   stg_p0_d, stg_p0_q;
    s1_t                   stg_p1_d, stg_p1_q;
    logic                  vld_p0_q, vld_p1_q;
    logic                  inc;
    logic [OUT_WIDTH:0]    mag_r;
    logic                  sat;
    logic [OUT_WIDTH-1:0]  res_d;

    // ---- stage 0: unpack fields, class flags and alignment shift ----
    always_comb begin
        expo              = Oprand[DATA_WIDTH-2 -: EXPO_WIDTH];
        mant              = Oprand[MANT_WIDTH-1:0];
        stg_p0_d.sign     = Oprand[DATA_WIDTH-1];
        stg_p0_d.zero_den = (expo == '0);
        stg_p0_d.inf      = (expo == EXPO_WIDTH'(EXPO_ALL_ONES)) && (mant == '0);
        stg_p0_d.nan      = (expo == EXPO_WIDTH'(EXPO_ALL_ONES)) && (mant != '0);
        stg_p0_d.sh       = SH_W'(expo) - SH_W'(EXPO_BIAS + MANT_WIDTH)
                          + SH_W'(frac_bits);
        stg_p0_d.m24      = {1'b1, mant};
    end

    dff_en #(.W($bits(s0_t))) u_stg_p0 (
        .clk(clk), .rst(rst), .en_i(en), .d_i(stg_p0_d), .q_o(stg_p0_q)
    );
    dff_en #(.W(1)) u_vld_p0 (
        .clk(clk), .rst(rst), .en_i(en), .d_i(vld_in), .q_o(vld_p0_q)
    );

    // ---- stage 1: align significand into the fixed-point grid ----
    fix_align_shifter #(
        .MANT_WIDTH(MANT_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SH_W      (SH_W)
    ) u_align (
        .m24_i   (stg_p0_q.m24),
        .sh_i    (stg_p0_q.sh),
        .mag_o   (stg_p1_d.mag),
        .guard_o (stg_p1_d.guard),
        .sticky_o(stg_p1_d.sticky),
        .ovf_o   (stg_p1_d.ovf)
    );

    assign stg_p1_d.sign     = stg_p0_q.sign;
    assign stg_p1_d.zero_den = stg_p0_q.zero_den;
    assign stg_p1_d.inf      = stg_p0_q.inf;
    assign stg_p1_d.nan      = stg_p0_q.nan;

    dff_en #(.W($bits(s1_t))) u_stg_p1 (
        .clk(clk), .rst(rst), .en_i(en), .d_i(stg_p1_d), .q_o(stg_p1_q)
    );
    dff_en #(.W(1)) u_vld_p1 (
        .clk(clk), .rst(rst), .en_i(en), .d_i(vld_p0_q), .q_o(vld_p1_q)
    );

    // ---- stage 2: round to nearest-even, apply sign, saturate, specials ----
    always_comb begin
        inc   = rne_inc(stg_p1_q.guard, stg_p1_q.sticky, stg_p1_q.mag[0]);
        mag_r = {1'b0, stg_p1_q.mag} + (OUT_WIDTH+1)'(inc);
        sat   = sat_check(stg_p1_q.sign, stg_p1_q.ovf, mag_r);
        if (stg_p1_q.nan) begin
            res_d = MAXP;
        end else if (stg_p1_q.inf) begin
            res_d = stg_p1_q.sign ? MINN : MAXP;
        end else if (stg_p1_q.zero_den) begin
            res_d = '0;
        end else if (sat) begin
            res_d = stg_p1_q.sign ? MINN : MAXP;
        end else begin
            res_d = stg_p1_q.sign ? (OUT_WIDTH'(0) - mag_r[OUT_WIDTH-1:0])
                                  : mag_r[OUT_WIDTH-1:0];
        end
    end

    dff_en #(.W(OUT_WIDTH)) u_res_p2 (
        .clk(clk), .rst(rst), .en_i(en), .d_i(res_d), .q_o(Result)
    );
    dff_en #(.W(1)) u_vld_p2 (
        .clk(clk), .rst(rst), .en_i(en), .d_i(vld_p1_q), .q_o(vld_out)
    );

`ifdef FP2FIX_STATUS_EN
    logic       sat_flag;
    logic       inexact;
    logic [2:0] status_d;

    // Status flags follow the same classification as the result mux.
    always_comb begin
        sat_flag = stg_p1_q.inf
                 | (!stg_p1_q.nan && !stg_p1_q.zero_den && sat);
        inexact  = (stg_p1_q.guard | stg_p1_q.sticky) && !sat_flag
                 && !stg_p1_q.nan && !stg_p1_q.zero_den;
        status_d = {stg_p1_q.nan, sat_flag, inexact};
    end

    dff_en #(.W(3)) u_status_p2 (
        .clk(clk), .rst(rst), .en_i(en), .d_i(status_d), .q_o(status)
    );
`endif

endmodule
